branch_predict_unit: RTL
========================

# branch_predict_unit

Parametrised branch resolution and prediction unit for the RISC-V core: a direct-mapped branch target buffer (BTB) with 2-bit saturating counters and a sticky halt controller. Fetch reads the table to steer the next PC. Execute resolves branches, jal and jalr, updates the table, and raises a redirect on misprediction or halt. It sits between the IF PC mux and the EX stage, and provides the PC-select and target outputs with richer behaviour.

## Interface
- PC_W, 9, PC width in bits; must satisfy PC_W >= IDX_W+3
- IDX_W, 4, BTB index width; 2**IDX_W entries
- CNT_W, 16, width of statistics counters
- clk  in  1  core clock; all state updates on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- if_pc  in  PC_W  fetch-stage PC
- pred_taken  out  1  fetch prediction: redirect fetch to pred_target
- pred_target  out  32  predicted target, zero-extended from PC_W
- pc_four  out  32  {zero-ext if_pc} + 4
- ex_valid  in  1  valid instruction in EX
- ex_pc  in  PC_W  PC of EX instruction
- ex_imm  in  32  immediate of EX instruction
- ex_branch  in  1  conditional branch
- ex_jump  in  1  jal or jalr
- ex_jalr  in  1  jalr (qualifies ex_jump)
- ex_alu_result  in  32  bit0 = branch condition; full value = jalr target
- ex_pred_taken  in  1  prediction made for this instruction in IF, piped along
- ex_pred_target  in  32  target predicted in IF, piped along
- flag_halt  in  1  halt request from EX
- redirect  out  1  flush IF/ID and load redirect_pc
- redirect_pc  out  32  corrected PC
- halted  out  1  sticky halt state
- branch_cnt  out  CNT_W  resolved branches and jumps
- mispredict_cnt  out  CNT_W  mispredictions

## Operation
- Entry fields: valid, tag = pc[PC_W-1:IDX_W+2], target[PC_W-1:0], jmp, ctr[1:0]. Index = pc[IDX_W+1:2].
- Lookup on if_pc is combinational from registered state.
  - hit = valid && tag match.
  - pred_taken = hit && (jmp || ctr[1]).
  - pred_target = hit ? zero-ext target : 0.
- Resolution, all signals are combinational and valid only when ex_valid:
  - actual_target = ex_jalr ? {ex_alu_result[31:1],1'b0} : zero-ext(ex_pc)+ex_imm, truncated to 32 bits.
  - actual_taken = ex_jump || (ex_branch && ex_alu_result[0]).
  - mispredict = (actual_taken != ex_pred_taken) || (actual_taken && actual_target != ex_pred_target).
  - A non-control instruction with ex_pred_taken=1 (alias) is a mispredict with actual_taken=0.
- redirect and redirect_pc:
  - halt active (flag_halt or halted): redirect=1, redirect_pc=halt_pc.
  - otherwise redirect = ex_valid && mispredict, and redirect_pc = actual_taken ? actual_target : zero-ext(ex_pc)+4.
  - Else redirect_pc=0.
- Table update at posedge, when ex_valid && !flag_halt && !halted:
  - jump: write valid=1, tag, target=actual_target[PC_W-1:0], jmp=1, ctr=2'b11.
  - branch hit: counter saturating +1 if taken, -1 if not (3 stays 3, 0 stays 0); target rewritten if taken.
  - branch miss: allocate only if taken (jmp=0, ctr=2'b10). A not-taken miss writes nothing.
  - alias (non-control, tag hit): clear valid.
- Counters, frozen while halted, saturating at all-ones:
  - branch_cnt increments on each updating branch or jump.
  - mispredict_cnt increments when redirect is caused by mispredict.
- Halt: flag_halt captures halt_pc = zero-ext(ex_pc) and sets halted. Both are sticky until rst_n low; later flag_halt pulses are ignored. Halt overrides mispredict.

## Timing
- Reset (rst_n low, async): all valid=0, ctr=0, halted=0, halt_pc=0, both counters=0. Hence pred_taken=0 and pred_target=0. redirect=0 unless flag_halt or a mispredict is present on the inputs.
- Lookup latency: 0 cycles, combinational from if_pc.
- Resolution and redirect: 0 cycles, combinational from EX inputs. State changes at the next edge.
- Same-cycle update and lookup of one index: lookup returns the pre-update entry; no bypass.
- Halt: redirect asserts in the flag_halt cycle, using redirect_pc = ex_pc directly. It stays asserted every cycle after with the stored halt_pc.
- Reset deasserted mid-halt: returns to empty table, no redirect.

## Test plan
- Reset, if_pc=0x010 -> pred_taken=0, pred_target=0, pc_four=0x14, all counters 0.
- Taken beq at ex_pc=0x020, imm=0x40, ex_pred_taken=0 -> redirect=1, redirect_pc=0x60, mispredict_cnt=1. Next cycle if_pc=0x020 -> pred_taken=1 (ctr=2), pred_target=0x60.
- Same branch resolved not-taken twice, predicted per table:
  - first -> redirect_pc=0x24, ctr 2→1.
  - second (pred 0) -> redirect=0, ctr 1→0.
  - counter never underflows.
- jalr at 0x030, alu=0x105 -> redirect_pc=0x104, entry jmp=1. Repeat with ex_pred_target=0x104 -> redirect=0, branch_cnt=2.
- Alias: 0x020 and 0x060 share index (IDX_W=4). Non-control at 0x020 with ex_pred_taken=1 -> redirect_pc=0x24 and entry invalidated.
- flag_halt pulse with ex_pc=0x044 and a simultaneous mispredict:
  - redirect_pc=0x44 then and every later cycle; halted=1; counters frozen.
  - rst_n low mid-halt clears everything.

Source files
------------

// File: rtl/branch_predict_unit_if.sv
// rtl/branch_predict_unit_if.sv - fetch/execute signal bundle for branch_predict_unit
interface branch_predict_unit_if #(
    parameter int PC_W = 9
);
    logic [PC_W-1:0] if_pc;
    logic            pred_taken;
    logic [31:0]     pred_target;
    logic [31:0]     pc_four;

    logic            ex_valid;
    logic [PC_W-1:0] ex_pc;
    logic [31:0]     ex_imm;
    logic            ex_branch;
    logic            ex_jump;
    logic            ex_jalr;
    logic [31:0]     ex_alu_result;
    logic            ex_pred_taken;
    logic [31:0]     ex_pred_target;
    logic            flag_halt;

    logic            redirect;
    logic [31:0]     redirect_pc;
    logic            halted;

    modport master (
        output if_pc, ex_valid, ex_pc, ex_imm, ex_branch, ex_jump, ex_jalr,
               ex_alu_result, ex_pred_taken, ex_pred_target, flag_halt,
        input  pred_taken, pred_target, pc_four, redirect, redirect_pc, halted
    );

    modport slave (
        input  if_pc, ex_valid, ex_pc, ex_imm, ex_branch, ex_jump, ex_jalr,
               ex_alu_result, ex_pred_taken, ex_pred_target, flag_halt,
        output pred_taken, pred_target, pc_four, redirect, redirect_pc, halted
    );
endinterface

// File: rtl/branch_predict_unit.sv
// rtl/branch_predict_unit.sv - direct-mapped BTB with 2-bit counters, EX resolution and sticky halt
module branch_predict_unit #(
    parameter int PC_W  = 9,
    parameter int IDX_W = 4,
    parameter int CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    branch_predict_unit_if.slave bpu,
    output logic [CNT_W-1:0]     branch_cnt,
    output logic [CNT_W-1:0]     mispredict_cnt
);
    localparam int ENTRIES = 1 << IDX_W;
    localparam int TAG_W   = PC_W - IDX_W - 2;

    logic [ENTRIES-1:0] valid_q;
    logic [ENTRIES-1:0] jmp_q;
    logic [TAG_W-1:0]   tag_q    [ENTRIES];
    logic [PC_W-1:0]    target_q [ENTRIES];
    logic [1:0]         ctr_q    [ENTRIES];

    logic               halted_q;
    logic [31:0]        halt_pc_q;

    logic [IDX_W-1:0]   if_idx;
    logic               if_hit;
    logic [IDX_W-1:0]   ex_idx;
    logic [TAG_W-1:0]   ex_tag;
    logic               ex_hit;
    logic [31:0]        if_pc32;
    logic [31:0]        ex_pc32;
    logic [31:0]        actual_target;
    logic               actual_taken;
    logic               mispredict;
    logic               halt_active;
    logic               upd_en;
    logic [1:0]         ctr_next;

    assign if_pc32 = {{(32-PC_W){1'b0}}, bpu.if_pc};
    assign ex_pc32 = {{(32-PC_W){1'b0}}, bpu.ex_pc};

    // Fetch-side lookup reads registered state only, so a same-cycle update is not visible
    assign if_idx          = bpu.if_pc[IDX_W+1:2];
    assign if_hit          = valid_q[if_idx] && (tag_q[if_idx] == bpu.if_pc[PC_W-1:IDX_W+2]);
    assign bpu.pred_taken  = if_hit && (jmp_q[if_idx] || ctr_q[if_idx][1]);
    assign bpu.pred_target = if_hit ? {{(32-PC_W){1'b0}}, target_q[if_idx]} : 32'd0;
    assign bpu.pc_four     = if_pc32 + 32'd4;

    assign ex_idx        = bpu.ex_pc[IDX_W+1:2];
    assign ex_tag        = bpu.ex_pc[PC_W-1:IDX_W+2];
    assign ex_hit        = valid_q[ex_idx] && (tag_q[ex_idx] == ex_tag);
    assign actual_target = bpu.ex_jalr ? {bpu.ex_alu_result[31:1], 1'b0} : ex_pc32 + bpu.ex_imm;
    assign actual_taken  = bpu.ex_jump || (bpu.ex_branch && bpu.ex_alu_result[0]);
    assign mispredict    = (actual_taken != bpu.ex_pred_taken) ||
                           (actual_taken && (actual_target != bpu.ex_pred_target));
    assign halt_active   = bpu.flag_halt || halted_q;
    assign upd_en        = bpu.ex_valid && !halt_active;
    assign bpu.halted    = halted_q;

    always_comb begin
        ctr_next = ctr_q[ex_idx];
        if (actual_taken) begin
            if (ctr_q[ex_idx] != 2'b11) ctr_next = ctr_q[ex_idx] + 2'd1;
        end else begin
            if (ctr_q[ex_idx] != 2'b00) ctr_next = ctr_q[ex_idx] - 2'd1;
        end
    end

    // On the first halt cycle the stored PC is not yet captured, so ex_pc is forwarded
    always_comb begin
        bpu.redirect    = 1'b0;
        bpu.redirect_pc = 32'd0;
        if (halt_active) begin
            bpu.redirect    = 1'b1;
            bpu.redirect_pc = halted_q ? halt_pc_q : ex_pc32;
        end else if (bpu.ex_valid && mispredict) begin
            bpu.redirect    = 1'b1;
            bpu.redirect_pc = actual_taken ? actual_target : ex_pc32 + 32'd4;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            jmp_q   <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                tag_q[i]    <= '0;
                target_q[i] <= '0;
                ctr_q[i]    <= 2'b00;
            end
        end else if (upd_en) begin
            if (bpu.ex_jump) begin
                valid_q[ex_idx]  <= 1'b1;
                tag_q[ex_idx]    <= ex_tag;
                target_q[ex_idx] <= actual_target[PC_W-1:0];
                jmp_q[ex_idx]    <= 1'b1;
                ctr_q[ex_idx]    <= 2'b11;
            end else if (bpu.ex_branch) begin
                if (ex_hit) begin
                    ctr_q[ex_idx] <= ctr_next;
                    if (actual_taken) target_q[ex_idx] <= actual_target[PC_W-1:0];
                end else if (actual_taken) begin
                    valid_q[ex_idx]  <= 1'b1;
                    tag_q[ex_idx]    <= ex_tag;
                    target_q[ex_idx] <= actual_target[PC_W-1:0];
                    jmp_q[ex_idx]    <= 1'b0;
                    ctr_q[ex_idx]    <= 2'b10;
                end
            end else if (ex_hit) begin
                valid_q[ex_idx] <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            halted_q  <= 1'b0;
            halt_pc_q <= 32'd0;
        end else if (bpu.flag_halt && !halted_q) begin
            halted_q  <= 1'b1;
            halt_pc_q <= ex_pc32;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            branch_cnt     <= '0;
            mispredict_cnt <= '0;
        end else if (!halt_active) begin
            if (upd_en && (bpu.ex_branch || bpu.ex_jump) && (branch_cnt != '1))
                branch_cnt <= branch_cnt + 1'b1;
            if (bpu.ex_valid && mispredict && (mispredict_cnt != '1))
                mispredict_cnt <= mispredict_cnt + 1'b1;
        end
    end
endmodule
